memwr_scoreboard: RTL and testbench

- Synthesizable, parametrised memory-write checker for processor self-test.
- Watches the data-memory write bus (MemWrite, DataAdr, WriteData) of the processor core.
- Compares each write, in order, against a programmable table of expected (address, data) pairs. One programmable address can be excluded as a scratch address.
- Reports sticky pass/fail with failure capture, so the same check runs in simulation and on the FPGA board.

---
 rtl/memwr_scoreboard_pkg.sv | 26 ++
 rtl/memwr_scoreboard_if.sv | 12 +
 rtl/memwr_exp_table.sv | 46 ++++
 rtl/memwr_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_memwr_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memwr_scoreboard_pkg.sv
// Shared types, default widths and width helpers for the memory-write scoreboard.
package memwr_scoreboard_pkg;

    localparam int unsigned AW_DEF      = 32;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    // Table index width; never narrower than one bit so DEPTH=1 still has a port.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold a count of 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/memwr_scoreboard_if.sv
// Data-memory write bus of the core as seen by the scoreboard.
interface memwr_scoreboard_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;

    modport master (output MemWrite, output DataAdr, output WriteData);
    modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/memwr_exp_table.sv
// Expected-write table: synchronous write port, combinational read at the run pointer.
module memwr_exp_table
    import memwr_scoreboard_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [idx_w(DEPTH)-1:0]  widx,
    input  logic [AW-1:0]            wadr,
    input  logic [DW-1:0]            wdata,
    input  logic [idx_w(DEPTH)-1:0]  ridx,
    output logic [AW-1:0]            radr_c,
    output logic [DW-1:0]            rdata_c
);

    // Entry layout sized from this module's parameters.
    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t mem [DEPTH];
    entry_t rd_c;

    // Table contents survive reset on purpose, so no reset branch here.
    always_ff @(posedge clk) begin
        if (we && (32'(widx) < DEPTH)) begin
            mem[widx] <= '{adr: wadr, data: wdata};
        end
    end

    // Out-of-range pointer reads as zero.
    always_comb begin
        rd_c = '0;
        if (32'(ridx) < DEPTH) begin
            rd_c = mem[ridx];
        end
    end

    assign radr_c  = rd_c.adr;
    assign rdata_c = rd_c.data;

endmodule

// File: rtl/memwr_scoreboard.sv
// In-order memory-write checker with sticky pass/fail and failure capture.
// Optional watchdog enabled by defining MEMWR_SCOREBOARD_TIMEOUT_EN.
module memwr_scoreboard
    import memwr_scoreboard_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cfg_we,
    input  logic [idx_w(DEPTH)-1:0]  cfg_idx,
    input  logic [AW-1:0]            cfg_adr,
    input  logic [DW-1:0]            cfg_data,
    input  logic [cnt_w(DEPTH)-1:0]  cfg_count,
    input  logic                     ign_en,
    input  logic [AW-1:0]            ign_adr,
    memwr_scoreboard_if.slave        bus,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [cnt_w(DEPTH)-1:0]  match_cnt,
    output logic [AW-1:0]            fail_adr,
    output logic [DW-1:0]            fail_data
);

    localparam int unsigned IW = idx_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    state_t          state_q, state_n;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_lim_c;
    logic [AW-1:0]   exp_adr_c;
    logic [DW-1:0]   exp_data_c;
    logic            ignored_c, match_c, last_c;
    logic            start_c, accept_c, capture_c, tmo_hit_c, tmo_expire_c;

    memwr_exp_table #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_table (
        .clk     (clk),
        .we      (cfg_we && (state_q != RUN)),
        .widx    (cfg_idx),
        .wadr    (cfg_adr),
        .wdata   (cfg_data),
        .ridx    (ptr_q),
        .radr_c  (exp_adr_c),
        .rdata_c (exp_data_c)
    );

    assign cnt_lim_c = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;
    assign ignored_c = ign_en && (bus.DataAdr == ign_adr);
    assign match_c   = (bus.DataAdr == exp_adr_c) && (bus.WriteData == exp_data_c);
    assign last_c    = (CW'(ptr_q) == (cnt_q - CW'(1)));

`ifdef MEMWR_SCOREBOARD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q;

    // Idle watchdog: restarts on start and on every accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (start_c || accept_c) begin
            tmo_q <= '0;
        end else if (state_q == RUN) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Fires on the edge that would bring the counter to TIMEOUT.
    assign tmo_expire_c = (state_q == RUN) && (tmo_q == TW'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT);
    assign tmo_expire_c       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and datapath controls; a matching final write beats the watchdog.
    always_comb begin
        state_n   = state_q;
        start_c   = 1'b0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        tmo_hit_c = 1'b0;
        case (state_q)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    start_c = 1'b1;
                    state_n = (cnt_lim_c == '0) ? PASS : RUN;
                end
            end
            RUN: begin
                if (bus.MemWrite && !ignored_c) begin
                    if (match_c) begin
                        accept_c = 1'b1;
                        if (last_c) begin
                            state_n = PASS;
                        end
                    end else begin
                        capture_c = 1'b1;
                        state_n   = FAIL;
                    end
                end else if (tmo_expire_c) begin
                    tmo_hit_c = 1'b1;
                    state_n   = FAIL;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Run pointer, match count, failure capture and watchdog flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            match_cnt <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
            timeout   <= 1'b0;
        end else begin
            if (start_c) begin
                ptr_q     <= '0;
                cnt_q     <= cnt_lim_c;
                match_cnt <= '0;
                fail_adr  <= '0;
                fail_data <= '0;
                timeout   <= 1'b0;
            end
            if (accept_c) begin
                ptr_q     <= ptr_q + IW'(1);
                match_cnt <= match_cnt + CW'(1);
            end
            if (capture_c) begin
                fail_adr  <= bus.DataAdr;
                fail_data <= bus.WriteData;
            end
            if (tmo_hit_c) begin
                timeout <= 1'b1;
            end
        end
    end

    // Status flags registered from the next state so they track state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            busy <= (state_n == RUN);
            done <= (state_n == PASS) || (state_n == FAIL);
            pass <= (state_n == PASS);
            fail <= (state_n == FAIL);
        end
    end

endmodule

// File: tb/tb_memwr_scoreboard.sv
// Self-checking bench for memwr_scoreboard against a behavioural reference model.
module tb_memwr_scoreboard;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 6;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned IW      = 3;
    localparam int unsigned CW      = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_adr;
    logic [DW-1:0] cfg_data;
    logic [CW-1:0] cfg_count;
    logic          ign_en;
    logic [AW-1:0] ign_adr;
    logic          busy, done, pass, fail, timeout;
    logic [CW-1:0] match_cnt;
    logic [AW-1:0] fail_adr;
    logic [DW-1:0] fail_data;

    memwr_scoreboard_if #(.AW(AW), .DW(DW)) bus_if ();

    memwr_scoreboard #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_adr   (cfg_adr),
        .cfg_data  (cfg_data),
        .cfg_count (cfg_count),
        .ign_en    (ign_en),
        .ign_adr   (ign_adr),
        .bus       (bus_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .match_cnt (match_cnt),
        .fail_adr  (fail_adr),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: programmed table plus the verdict of the current run.
    logic [AW-1:0] tab_adr  [DEPTH];
    logic [DW-1:0] tab_data [DEPTH];
    bit            m_run, m_pass, m_fail, m_tmo;
    int            m_k, m_cnt, m_idle;
    logic [AW-1:0] m_fadr;
    logic [DW-1:0] m_fdata;

    task automatic model_reset();
        m_run = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
        m_k = 0; m_cnt = 0; m_idle = 0;
        m_fadr = '0; m_fdata = '0;
    endtask

    // Applies the rules to what the bench is driving into the coming clock edge.
    task automatic model_edge();
        int c;
        if (m_run) begin
            if (bus_if.MemWrite && !(ign_en && bus_if.DataAdr == ign_adr)) begin
                if (bus_if.DataAdr == tab_adr[m_k] && bus_if.WriteData == tab_data[m_k]) begin
                    m_k++;
                    m_idle = 0;
                    if (m_k == m_cnt) begin
                        m_run = 0; m_pass = 1;
                    end
                end else begin
                    m_run = 0; m_fail = 1;
                    m_fadr = bus_if.DataAdr; m_fdata = bus_if.WriteData;
                end
            end else begin
`ifdef MEMWR_SCOREBOARD_TIMEOUT_EN
                m_idle++;
                if (m_idle == int'(TIMEOUT)) begin
                    m_run = 0; m_fail = 1; m_tmo = 1;
                end
`endif
            end
        end else begin
            if (start) begin
                c = int'(cfg_count);
                if (c > int'(DEPTH)) c = int'(DEPTH);
                m_cnt = c; m_k = 0; m_idle = 0;
                m_fadr = '0; m_fdata = '0; m_tmo = 0;
                m_pass = (c == 0); m_fail = 0; m_run = (c != 0);
            end
            if (cfg_we && int'(cfg_idx) < int'(DEPTH)) begin
                tab_adr[cfg_idx]  = cfg_adr;
                tab_data[cfg_idx] = cfg_data;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},      64'(busy),      64'(m_run));
        chk({tag, ".done"},      64'(done),      64'(m_pass | m_fail));
        chk({tag, ".pass"},      64'(pass),      64'(m_pass));
        chk({tag, ".fail"},      64'(fail),      64'(m_fail));
        chk({tag, ".timeout"},   64'(timeout),   64'(m_tmo));
        chk({tag, ".match_cnt"}, 64'(match_cnt), 64'(m_k));
        chk({tag, ".fail_adr"},  64'(fail_adr),  64'(m_fadr));
        chk({tag, ".fail_data"}, 64'(fail_data), 64'(m_fdata));
    endtask

    task automatic cfg_entry(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_adr = a; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic do_start(input int c);
        cfg_count = CW'(c); start = 1;
        tick();
        start = 0;
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_if.MemWrite = 1; bus_if.DataAdr = a; bus_if.WriteData = d;
        tick();
        bus_if.MemWrite = 0;
    endtask

    task automatic idle_chk(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all(tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n, r;
        rst = 0; start = 0; cfg_we = 0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
        cfg_count = '0; ign_en = 0; ign_adr = '0;
        bus_if.MemWrite = 0; bus_if.DataAdr = '0; bus_if.WriteData = '0;
        model_reset();

        // Reset state
        #1 rst = 1;
        #2 check_all("reset");
        @(negedge clk) rst = 0;
        tick();
        check_all("reset_rel");

        // Ignored scratch write, then matching single entry
        ign_en = 1; ign_adr = 32'd96;
        cfg_entry(0, 32'd100, 32'd7);
        do_start(1);
        check_all("one.start");
        bus_wr(32'd96, 32'd3);
        check_all("one.ignored");
        bus_wr(32'd100, 32'd7);
        check_all("one.pass");
        chk("one.pass_const", 64'(pass), 64'd1);

        // Mismatching data with capture; later writes leave the verdict alone
        do_start(1);
        bus_wr(32'd100, 32'd8);
        check_all("mis.fail");
        chk("mis.fail_data_const", 64'(fail_data), 64'd8);
        bus_wr(32'd100, 32'd7);
        check_all("mis.sticky");

        // Three entries with idle gaps, run twice
        cfg_entry(0, 32'h10, 32'd1);
        cfg_entry(1, 32'h14, 32'd2);
        cfg_entry(2, 32'h18, 32'd3);
        for (int rep = 0; rep < 2; rep++) begin
            do_start(3);
            bus_wr(32'h10, 32'd1); idle_chk(2, "three.a");
            bus_wr(32'h14, 32'd2); idle_chk(2, "three.b");
            bus_wr(32'h18, 32'd3); check_all("three.c");
        end

        // Zero-length run passes at once; later writes unchecked
        do_start(0);
        check_all("zero.start");
        bus_wr(32'h0, 32'h0);
        check_all("zero.wr");

        // Reset mid-run, then rerun on the retained table
        do_start(3);
        bus_wr(32'h10, 32'd1);
        check_all("abort.one");
        rst = 1;
        model_reset();
        #2 check_all("abort.reset");
        @(negedge clk) rst = 0;
        tick();
        do_start(3);
        bus_wr(32'h10, 32'd1);
        bus_wr(32'h14, 32'd2);
        bus_wr(32'h18, 32'd3);
        check_all("abort.rerun");

        // Table writes and start pulses during RUN are ignored
        do_start(3);
        cfg_entry(0, 32'h99, 32'd9);
        bus_wr(32'h10, 32'd1);
        do_start(0);
        check_all("run.ignore");
        bus_wr(32'h14, 32'd2);
        bus_wr(32'h18, 32'd3);
        check_all("run.pass");

        // Table write on the same edge as start is seen by the first compare
        cfg_we = 1; cfg_idx = 3'd0; cfg_adr = 32'h20; cfg_data = 32'd5;
        cfg_count = 3'd1; start = 1;
        tick();
        cfg_we = 0; start = 0;
        bus_wr(32'h20, 32'd5);
        check_all("same_edge");

        // Count clamps to DEPTH; out-of-range indices do not disturb the table
        for (int i = 0; i < int'(DEPTH); i++) cfg_entry(i, 32'h100 + 32'(4 * i), 32'(i + 10));
        cfg_entry(6, 32'hdead, 32'hbeef);
        cfg_entry(7, 32'hdead, 32'hbeef);
        do_start(7);
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus_wr(32'h100 + 32'(4 * i), 32'(i + 10));
            check_all("clamp");
        end

        // Long idle in RUN: watchdog build fails after TIMEOUT cycles, else keeps waiting
        cfg_entry(0, 32'h40, 32'd4);
        do_start(1);
        idle_chk(int'(TIMEOUT) - 1, "tmo.wait");
        tick();
        check_all("tmo.edge");
`ifdef MEMWR_SCOREBOARD_TIMEOUT_EN
        chk("tmo.flag_const", 64'(timeout), 64'd1);
`endif
        if (m_run) begin
            bus_wr(32'h40, 32'd4);
            check_all("tmo.late");
        end
        do_start(1);
        idle_chk(int'(TIMEOUT) - 1, "tmo.win_wait");
        bus_wr(32'h40, 32'd4);
        check_all("tmo.write_wins");

        // Randomized runs against the model
        for (int run = 0; run < 30; run++) begin
            ign_en  = 1'($urandom_range(0, 1));
            ign_adr = $urandom | 32'h1;
            n = $urandom_range(1, int'(DEPTH));
            for (int i = 0; i < n; i++) cfg_entry(i, $urandom & ~32'h1, $urandom);
            do_start((n == int'(DEPTH) && $urandom_range(0, 1) == 1) ? 7 : n);
            check_all("rnd.start");
            for (int s = 0; s < 40 && m_run; s++) begin
                r = $urandom_range(0, 9);
                if (r < 6)       bus_wr(tab_adr[m_k], tab_data[m_k]);
                else if (r < 8)  bus_wr(ign_adr, $urandom);
                else if (r == 8) bus_wr(tab_adr[m_k], tab_data[m_k] ^ (32'h1 << $urandom_range(0, 31)));
                else             tick();
                check_all("rnd.step");
            end
            if (m_run) begin
                rst = 1;
                model_reset();
                #2 check_all("rnd.reset");
                @(negedge clk) rst = 0;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
